// File: rtl/io_bus_responder_pkg.sv
// Shared definitions for the IO bus responder: register addresses,
// the active-low hex-to-7-segment decoder and a counter-sizing helper.
package io_pkg;

    localparam logic [7:0] ADDR_LED        = 8'h00;
    localparam logic [7:0] ADDR_SW_STATUS  = 8'h04;
    localparam logic [7:0] ADDR_SW_DATA    = 8'h08;
    localparam logic [7:0] ADDR_SEG_STATUS = 8'h0C;
    localparam logic [7:0] ADDR_SEG_DATA   = 8'h10;

    // Bits needed for a counter that must hold values 0..max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    // Pattern is {g,f,e,d,c,b,a}; a 0 lights the segment.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = 7'b1000000;
            4'h1:    pat = 7'b1111001;
            4'h2:    pat = 7'b0100100;
            4'h3:    pat = 7'b0110000;
            4'h4:    pat = 7'b0011001;
            4'h5:    pat = 7'b0010010;
            4'h6:    pat = 7'b0000010;
            4'h7:    pat = 7'b1111000;
            4'h8:    pat = 7'b0000000;
            4'h9:    pat = 7'b0010000;
            4'hA:    pat = 7'b0001000;
            4'hB:    pat = 7'b0000011;
            4'hC:    pat = 7'b1000110;
            4'hD:    pat = 7'b0100001;
            4'hE:    pat = 7'b0000110;
            default: pat = 7'b0001110;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/io_bus_responder_btn_debounce.sv
// Button conditioning: two-flop synchronizer, stability counter and a
// one-cycle pulse in the cycle whose edge raises the debounced level.
module btn_debounce
    import io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic rise
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d = btn;
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = '0;
        rise    = 1'b0;
        // Count only while the synchronized input disagrees; agreement
        // (a bounce back) restarts the count from zero.
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                rise    = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/io_bus_responder.sv
// Responder end of the CPU memory-mapped IO bus: register decode, LED latch,
// button-gated switch capture, 7-segment data handshake and digit scanning.
module io_bus_responder
    import io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int SCAN_DIV        = 50000,
    parameter int SEG_HOLD        = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  io_addr,
    input  logic [31:0] io_dout,
    input  logic        io_we,
    input  logic        io_re,
    output logic [31:0] io_din,
    input  logic [15:0] sw,
    input  logic        btn,
    output logic [15:0] led,
    output logic [7:0]  an,
    output logic [6:0]  seg
);

    localparam int HOLD_W = cnt_width(SEG_HOLD);
    localparam int SCAN_W = cnt_width(SCAN_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(SEG_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [SCAN_W-1:0] SCAN_ONE  = SCAN_W'(1);

    logic [15:0]       led_q, led_d;
    logic [15:0]       sw_data_q, sw_data_d;
    logic              sw_valid_q, sw_valid_d;
    logic [31:0]       seg_data_q, seg_data_d;
    logic              seg_ready_q, seg_ready_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [SCAN_W-1:0] scan_q, scan_d;
    logic [2:0]        idx_q, idx_d;
    logic [7:0]        an_q, an_d;
    logic [6:0]        seg_q, seg_d;
    logic              btn_rise;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk  (clk),
        .rst  (rst),
        .btn  (btn),
        .rise (btn_rise)
    );

    always_comb begin
        led_d       = led_q;
        sw_data_d   = sw_data_q;
        sw_valid_d  = sw_valid_q;
        seg_data_d  = seg_data_q;
        seg_ready_d = seg_ready_q;
        hold_d      = hold_q;
        scan_d      = scan_q;
        idx_d       = idx_q;

        if (io_we && io_addr == ADDR_LED) begin
            led_d = io_dout[15:0];
        end

        // Capture is evaluated after the read-clear so it wins a same-cycle race.
        if (io_re && io_addr == ADDR_SW_DATA) begin
            sw_valid_d = 1'b0;
        end
        if (btn_rise) begin
            sw_valid_d = 1'b1;
            sw_data_d  = sw;
        end

        if (!seg_ready_q) begin
            if (hold_q == HOLD_ONE) begin
                seg_ready_d = 1'b1;
                hold_d      = '0;
            end else begin
                hold_d = hold_q - HOLD_ONE;
            end
        end else if (io_we && io_addr == ADDR_SEG_DATA) begin
            seg_data_d  = io_dout;
            seg_ready_d = 1'b0;
            hold_d      = HOLD_LOAD;
        end

        if (scan_q == SCAN_LAST) begin
            scan_d = '0;
            idx_d  = idx_q + 3'd1;
        end else begin
            scan_d = scan_q + SCAN_ONE;
        end

        // Driven from the current index, so the display lags the index by one cycle.
        an_d  = ~(8'd1 << idx_q);
        seg_d = hex_to_seg(seg_data_q[{idx_q, 2'b00} +: 4]);
    end

    always_comb begin
        io_din = 32'd0;
        case (io_addr)
            ADDR_LED:        io_din = {16'd0, led_q};
            ADDR_SW_STATUS:  io_din = {31'd0, sw_valid_q};
            ADDR_SW_DATA:    io_din = {16'd0, sw_data_q};
            ADDR_SEG_STATUS: io_din = {31'd0, seg_ready_q};
            ADDR_SEG_DATA:   io_din = seg_data_q;
            default:         io_din = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            led_q       <= '0;
            sw_data_q   <= '0;
            sw_valid_q  <= 1'b0;
            seg_data_q  <= '0;
            seg_ready_q <= 1'b1;
            hold_q      <= '0;
            scan_q      <= '0;
            idx_q       <= '0;
            an_q        <= 8'hFE;
            seg_q       <= 7'b1000000;
        end else begin
            led_q       <= led_d;
            sw_data_q   <= sw_data_d;
            sw_valid_q  <= sw_valid_d;
            seg_data_q  <= seg_data_d;
            seg_ready_q <= seg_ready_d;
            hold_q      <= hold_d;
            scan_q      <= scan_d;
            idx_q       <= idx_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
        end
    end

    assign led = led_q;
    assign an  = an_q;
    assign seg = seg_q;

endmodule

// File: tb/tb_io_bus_responder.sv
// Directed bench for io_bus_responder with short debounce, scan and hold timings.
`timescale 1ns/1ps
module tb_io_bus_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  io_addr;
    logic [31:0] io_dout;
    logic        io_we;
    logic        io_re;
    logic [31:0] io_din;
    logic [15:0] sw;
    logic        btn;
    logic [15:0] led;
    logic [7:0]  an;
    logic [6:0]  seg;

    int nchk = 0;
    int nerr = 0;

    typedef struct {
        logic        we;
        logic        re;
        logic [7:0]  addr;
        logic [31:0] dout;
        logic [31:0] exp_din;
        logic [15:0] exp_led;
    } vec_t;

    vec_t       vecs [13];
    logic [6:0] seg_pat [16];

    io_bus_responder #(
        .DEBOUNCE_CYCLES(4),
        .SCAN_DIV(4),
        .SEG_HOLD(3)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .io_addr (io_addr),
        .io_dout (io_dout),
        .io_we   (io_we),
        .io_re   (io_re),
        .io_din  (io_din),
        .sw      (sw),
        .btn     (btn),
        .led     (led),
        .an      (an),
        .seg     (seg)
    );

    always #10 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Look at a register without any side effect or clock advance.
    task automatic peek(input string name, input logic [7:0] addr, input logic [31:0] exp);
        io_addr = addr;
        io_re   = 1'b0;
        #1;
        check(name, io_din, exp);
    endtask

    task automatic bus_write(input logic [7:0] addr, input logic [31:0] data);
        io_addr = addr;
        io_dout = data;
        io_we   = 1'b1;
        step();
        io_we   = 1'b0;
    endtask

    initial begin
        int rises;
        logic prev;
        int n;
        int k;

        seg_pat[0]  = 7'b1000000; seg_pat[1]  = 7'b1111001;
        seg_pat[2]  = 7'b0100100; seg_pat[3]  = 7'b0110000;
        seg_pat[4]  = 7'b0011001; seg_pat[5]  = 7'b0010010;
        seg_pat[6]  = 7'b0000010; seg_pat[7]  = 7'b1111000;
        seg_pat[8]  = 7'b0000000; seg_pat[9]  = 7'b0010000;
        seg_pat[10] = 7'b0001000; seg_pat[11] = 7'b0000011;
        seg_pat[12] = 7'b1000110; seg_pat[13] = 7'b0100001;
        seg_pat[14] = 7'b0000110; seg_pat[15] = 7'b0001110;

        // exp_din/exp_led reflect state before the row's own clock edge.
        vecs[0]  = '{1'b0, 1'b1, 8'h00, 32'h0,        32'h0000_0000, 16'h0000};
        vecs[1]  = '{1'b1, 1'b0, 8'h00, 32'hDEADBEEF, 32'h0000_0000, 16'h0000};
        vecs[2]  = '{1'b0, 1'b1, 8'h00, 32'h0,        32'h0000_BEEF, 16'hBEEF};
        vecs[3]  = '{1'b0, 1'b1, 8'h04, 32'h0,        32'h0000_0000, 16'hBEEF};
        vecs[4]  = '{1'b0, 1'b1, 8'h08, 32'h0,        32'h0000_0000, 16'hBEEF};
        vecs[5]  = '{1'b0, 1'b1, 8'h0C, 32'h0,        32'h0000_0001, 16'hBEEF};
        vecs[6]  = '{1'b0, 1'b1, 8'h10, 32'h0,        32'h0000_0000, 16'hBEEF};
        vecs[7]  = '{1'b1, 1'b0, 8'h14, 32'hFFFFFFFF, 32'h0000_0000, 16'hBEEF};
        vecs[8]  = '{1'b0, 1'b1, 8'h14, 32'h0,        32'h0000_0000, 16'hBEEF};
        vecs[9]  = '{1'b1, 1'b0, 8'h01, 32'h00001234, 32'h0000_0000, 16'hBEEF};
        vecs[10] = '{1'b0, 1'b1, 8'h00, 32'h0,        32'h0000_BEEF, 16'hBEEF};
        vecs[11] = '{1'b1, 1'b1, 8'h00, 32'h00005A5A, 32'h0000_BEEF, 16'hBEEF};
        vecs[12] = '{1'b0, 1'b1, 8'h00, 32'h0,        32'h0000_5A5A, 16'h5A5A};

        rst = 1'b1; io_addr = 8'h00; io_dout = '0; io_we = 1'b0; io_re = 1'b0;
        sw = 16'h0000; btn = 1'b0;
        step(); step();
        rst = 1'b0;
        check("reset_an", {24'd0, an}, 32'h0000_00FE);
        check("reset_seg", {25'd0, seg}, 32'h0000_0040);

        for (int i = 0; i < 13; i++) begin
            io_we   = vecs[i].we;
            io_re   = vecs[i].re;
            io_addr = vecs[i].addr;
            io_dout = vecs[i].dout;
            #1;
            check($sformatf("vec%0d_din", i), io_din, vecs[i].exp_din);
            check($sformatf("vec%0d_led", i), {16'd0, led}, {16'd0, vecs[i].exp_led});
            step();
        end
        io_we = 1'b0; io_re = 1'b0;

        // Held press: capture lands on the sixth edge after btn rises, once only.
        sw = 16'h1234; btn = 1'b1; io_addr = 8'h04;
        rises = 0; prev = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 10) btn = 1'b0;
            #1;
            if (i == 5) check("press_not_yet", io_din, 32'd0);
            if (i == 6) check("press_valid", io_din, 32'd1);
            if (io_din[0] && !prev) rises++;
            prev = io_din[0];
        end
        check("press_once", rises, 32'd1);
        io_addr = 8'h08; io_re = 1'b1; #1;
        check("sw_data_read", io_din, 32'h0000_1234);
        step(); io_re = 1'b0;
        peek("sw_valid_cleared", 8'h04, 32'd0);

        sw = 16'hFFFF; btn = 1'b1; step(); btn = 1'b0;
        repeat (10) step();
        peek("glitch1_no_capture", 8'h04, 32'd0);
        btn = 1'b1; repeat (3) step(); btn = 1'b0;
        repeat (10) step();
        peek("glitch3_no_capture", 8'h04, 32'd0);
        peek("glitch_data_kept", 8'h08, 32'h0000_1234);

        // Capture racing a read-clear of SW_DATA.
        sw = 16'h5555; btn = 1'b1; repeat (6) step();
        peek("race_pre_valid", 8'h04, 32'd1);
        btn = 1'b0; repeat (10) step();
        peek("fall_no_effect", 8'h04, 32'd1);
        btn = 1'b1; repeat (5) step();
        sw = 16'h00AA; io_addr = 8'h08; io_re = 1'b1; #1;
        check("race_old_data", io_din, 32'h0000_5555);
        step(); io_re = 1'b0;
        peek("race_valid_wins", 8'h04, 32'd1);
        peek("race_new_data", 8'h08, 32'h0000_00AA);
        btn = 1'b0; repeat (10) step();

        // Segment handshake: ready low for exactly three cycles.
        peek("seg_ready_idle", 8'h0C, 32'd1);
        bus_write(8'h10, 32'h89ABCDEF);
        peek("hold_c1", 8'h0C, 32'd0);
        step();
        io_addr = 8'h10; io_dout = 32'h11111111; io_we = 1'b1; #1;
        check("hold_c2_data", io_din, 32'h89ABCDEF);
        step(); io_we = 1'b0;
        peek("hold_c3", 8'h0C, 32'd0);
        step();
        peek("ready_back", 8'h0C, 32'd1);
        peek("dropped_write", 8'h10, 32'h89ABCDEF);
        bus_write(8'h10, 32'h76543210);
        peek("accepted_ready", 8'h0C, 32'd0);
        peek("accepted_data", 8'h10, 32'h76543210);

        // Scan: align to the first cycle of digit 1, then follow a full rotation.
        n = 0;
        while (an !== 8'hFE && n < 40) begin step(); n++; end
        check("scan_find_fe", {24'd0, an}, 32'h0000_00FE);
        n = 0;
        while (an !== 8'hFD && n < 40) begin step(); n++; end
        check("scan_find_fd", {24'd0, an}, 32'h0000_00FD);
        for (int i = 0; i < 32; i++) begin
            k = (1 + i / 4) % 8;
            check($sformatf("scan%0d_an", i), {24'd0, an}, {24'd0, ~(8'd1 << k)});
            check($sformatf("scan%0d_seg", i), {25'd0, seg}, {25'd0, seg_pat[k]});
            step();
        end

        // Reset in the middle of a debounce count and a segment hold.
        btn = 1'b1; step(); step();
        bus_write(8'h10, 32'hCAFE0000);
        peek("pre_rst_hold", 8'h0C, 32'd0);
        rst = 1'b1; btn = 1'b0; step(); rst = 1'b0;
        peek("rst_seg_ready", 8'h0C, 32'd1);
        peek("rst_sw_valid", 8'h04, 32'd0);
        peek("rst_seg_data", 8'h10, 32'd0);
        check("rst_an", {24'd0, an}, 32'h0000_00FE);
        check("rst_seg", {25'd0, seg}, 32'h0000_0040);
        check("rst_led", {16'd0, led}, 32'd0);
        repeat (3) step();
        check("rst_idx_hold", {24'd0, an}, 32'h0000_00FE);
        repeat (2) step();
        check("rst_idx_step", {24'd0, an}, 32'h0000_00FD);
        repeat (10) step();
        peek("rst_no_capture", 8'h04, 32'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
